sram_arbiter: RTL

Two-requester arbiter sharing the single 16-bit SRAM driver (`sram_driver_new`) between the CPU SRAM path (`sram_proc_new`, port m0) and a second bus master such as a UART-to-SRAM DMA loader (port m1). It sits between the requesters' valid/ready 16-bit transaction interfaces and the driver's identical interface. It grants one complete transaction at a time, with round-robin or fixed priority. It also watches for a driver that never completes.

---
 rtl/sram_bus_pkg.sv | 14 +
 rtl/sram_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sram_bus_pkg.sv
// Shared SRAM bus definitions used by the CPU SRAM path, the DMA loader and the arbiter.
// Widths match the 16-bit external SRAM behind sram_driver_new.
package sram_bus_pkg;

    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 16;
    localparam int WDOG_W      = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of sram_driver_new: one whole transaction per grant,
// round-robin or fixed priority, plus a sticky watchdog for a driver that never completes.
module sram_arbiter
    import sram_bus_pkg::*;
#(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   m0_valid,
    input  logic                   m0_we,
    input  logic [SRAM_ADDR_W-1:0] m0_addr,
    input  logic [SRAM_DATA_W-1:0] m0_wdata,
    output logic                   m0_ready,

    input  logic                   m1_valid,
    input  logic                   m1_we,
    input  logic [SRAM_ADDR_W-1:0] m1_addr,
    input  logic [SRAM_DATA_W-1:0] m1_wdata,
    output logic                   m1_ready,

    output logic [SRAM_DATA_W-1:0] m_rdata,

    output logic                   s_valid,
    output logic                   s_we,
    output logic [SRAM_ADDR_W-1:0] s_addr,
    output logic [SRAM_DATA_W-1:0] s_wdata,
    input  logic                   s_ready,
    input  logic [SRAM_DATA_W-1:0] s_rdata,

    output logic                   owner,
    output logic                   busy,
    output logic                   timeout
);

    localparam logic [WDOG_W-1:0] TIMEOUT_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

    arb_state_e             state_q;
    logic                   sValid_q;
    logic                   sWe_q;
    logic [SRAM_ADDR_W-1:0] sAddr_q;
    logic [SRAM_DATA_W-1:0] sWdata_q;
    logic                   owner_q;
    logic                   busy_q;
    logic                   timeout_q;
    logic [WDOG_W-1:0]      wdog_q;
    logic [WDOG_W-1:0]      wdog_d;

    logic                   grantValid;
    logic                   grantSel;
    logic                   selWe;
    logic [SRAM_ADDR_W-1:0] selAddr;
    logic [SRAM_DATA_W-1:0] selWdata;

    // On a tie, round-robin hands the grant to whoever did not own the bus last.
    always_comb begin
        grantValid = 1'b0;
        grantSel   = 1'b0;
        if (m0_valid && m1_valid) begin
            grantValid = 1'b1;
            grantSel   = (PRIORITY_MODE == 1) ? 1'b0 : ~owner_q;
        end else if (m0_valid) begin
            grantValid = 1'b1;
            grantSel   = 1'b0;
        end else if (m1_valid) begin
            grantValid = 1'b1;
            grantSel   = 1'b1;
        end
    end

    always_comb begin
        selWe    = grantSel ? m1_we    : m0_we;
        selAddr  = grantSel ? m1_addr  : m0_addr;
        selWdata = grantSel ? m1_wdata : m0_wdata;
    end

    always_comb begin
        wdog_d = (wdog_q == {WDOG_W{1'b1}}) ? wdog_q : wdog_q + 1'b1;
    end

    // The watchdog only flags a stuck driver; the transaction is never aborted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sValid_q  <= 1'b0;
            sWe_q     <= 1'b0;
            sAddr_q   <= '0;
            sWdata_q  <= '0;
            owner_q   <= 1'b1;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grantValid) begin
                        state_q  <= ST_BUSY;
                        sValid_q <= 1'b1;
                        busy_q   <= 1'b1;
                        owner_q  <= grantSel;
                        sWe_q    <= selWe;
                        sAddr_q  <= selAddr;
                        sWdata_q <= selWdata;
                        wdog_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    wdog_q <= wdog_d;
                    if (wdog_d >= TIMEOUT_LIMIT) begin
                        timeout_q <= 1'b1;
                    end
                    if (s_ready) begin
                        state_q  <= ST_IDLE;
                        sValid_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    sValid_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign s_valid  = sValid_q;
    assign s_we     = sWe_q;
    assign s_addr   = sAddr_q;
    assign s_wdata  = sWdata_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

    assign m0_ready = s_ready & busy_q & ~owner_q;
    assign m1_ready = s_ready & busy_q &  owner_q;
    assign m_rdata  = s_rdata;

endmodule
